// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with forwarding, operand select and load-use detect.
// Optional macro EX_FORWARD_EN enables EX/MEM and MEM/WB operand forwarding.
`default_nettype none

module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_val_i,
  input  logic [XLEN-1:0] id_rs2_val_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic [RA_W-1:0] id_rd_i,
  input  logic [3:0]      id_aluop_i,
  input  logic            id_srca_pc_i,
  input  logic            id_srcb_imm_i,
  input  logic            id_regwrite_i,
  input  logic            id_memread_i,
  input  logic            id_memwrite_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic            exmem_regwrite_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic            memwb_regwrite_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [3:0]      alu_op_o,
  output logic            ex_valid_o,
  output logic [RA_W-1:0] ex_rd_o,
  output logic            ex_regwrite_o,
  output logic            ex_memread_o,
  output logic            ex_memwrite_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic            ex_illegal_o,
  output logic            hazard_o
);

  logic            r_valid;
  logic            r_regwrite;
  logic            r_memread;
  logic            r_memwrite;
  logic            r_srca_pc;
  logic            r_srcb_imm;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [RA_W-1:0] r_rd;
  logic [3:0]      r_aluop;

  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;
  logic [XLEN-1:0] w_b_sel;
  logic            w_shift;
  logic            w_legal;
  logic            w_ex_hit;
  logic            w_load_use;
  logic            w_raw;

  // Flush only kills the control bits; payload fields simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_srca_pc  <= 1'b0;
      r_srcb_imm <= 1'b0;
      r_pc       <= '0;
      r_rs1_val  <= '0;
      r_rs2_val  <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_aluop    <= 4'b0000;
    end else if (flush_i) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (!stall_i) begin
      r_valid    <= id_valid_i;
      r_regwrite <= id_valid_i & id_regwrite_i;
      r_memread  <= id_valid_i & id_memread_i;
      r_memwrite <= id_valid_i & id_memwrite_i;
      r_srca_pc  <= id_srca_pc_i;
      r_srcb_imm <= id_srcb_imm_i;
      r_pc       <= id_pc_i;
      r_rs1_val  <= id_rs1_val_i;
      r_rs2_val  <= id_rs2_val_i;
      r_imm      <= id_imm_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
      r_aluop    <= id_aluop_i;
    end
  end

`ifdef EX_FORWARD_EN
  function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] idx,
                                          input logic [XLEN-1:0] latched);
    if (idx == '0)
      return '0;
    else if (exmem_regwrite_i && (exmem_rd_i == idx))
      return exmem_result_i;
    else if (memwb_regwrite_i && (memwb_rd_i == idx))
      return memwb_result_i;
    else
      return latched;
  endfunction

  always_comb begin
    w_rs1_fwd = fwd(r_rs1, r_rs1_val);
    w_rs2_fwd = fwd(r_rs2, r_rs2_val);
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exmem_result_i, memwb_result_i, r_rs1, r_rs2};

  always_comb begin
    w_rs1_fwd = r_rs1_val;
    w_rs2_fwd = r_rs2_val;
  end
`endif

  always_comb begin
    w_legal = 1'b0;
    case (r_aluop)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: w_legal = 1'b1;
      default:                                      w_legal = 1'b0;
    endcase
  end

  assign w_shift = (r_aluop == 4'b0001) || (r_aluop == 4'b0101) || (r_aluop == 4'b1101);
  assign w_b_sel = r_srcb_imm ? r_imm : w_rs2_fwd;

  // Shifts only consume the low five bits of the shift amount.
  assign alu_a_o         = r_srca_pc ? r_pc : w_rs1_fwd;
  assign alu_b_o         = w_b_sel & {{(XLEN-5){~w_shift}}, 5'h1f};
  assign alu_op_o        = r_aluop;
  assign ex_valid_o      = r_valid;
  assign ex_rd_o         = r_rd;
  assign ex_illegal_o    = r_valid & ~w_legal;
  assign ex_regwrite_o   = r_regwrite & ~ex_illegal_o;
  assign ex_memread_o    = r_memread;
  assign ex_memwrite_o   = r_memwrite & ~ex_illegal_o;
  assign ex_store_data_o = w_rs2_fwd;
  assign ex_pc_o         = r_pc;

  assign w_ex_hit   = (r_rd != '0) && ((r_rd == id_rs1_i) || (r_rd == id_rs2_i));
  assign w_load_use = r_valid & r_memread & w_ex_hit;

`ifdef EX_FORWARD_EN
  assign w_raw = 1'b0;
`else
  // Without forwarding every in-flight producer must drain before decode proceeds.
  assign w_raw = (r_valid & ex_regwrite_o & w_ex_hit)
               | (exmem_regwrite_i && (exmem_rd_i != '0) &&
                  ((exmem_rd_i == id_rs1_i) || (exmem_rd_i == id_rs2_i)))
               | (memwb_regwrite_i && (memwb_rd_i != '0) &&
                  ((memwb_rd_i == id_rs1_i) || (memwb_rd_i == id_rs2_i)));
`endif

  assign hazard_o = id_valid_i & (w_load_use | w_raw);

endmodule

`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed and randomized checks of ex_operand_stage.
`default_nettype none

module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, id_valid_i;
  logic [31:0] id_pc_i, id_rs1_val_i, id_rs2_val_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [3:0]  id_aluop_i;
  logic        id_srca_pc_i, id_srcb_imm_i, id_regwrite_i, id_memread_i, id_memwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic [31:0] exmem_result_i, memwb_result_i;
  logic [31:0] alu_a_o, alu_b_o, ex_store_data_o, ex_pc_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  ex_rd_o;
  logic        ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_illegal_o, hazard_o;

  int checks = 0;
  int errors = 0;

  ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs1_val_i(id_rs1_val_i),
    .id_rs2_val_i(id_rs2_val_i), .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_aluop_i(id_aluop_i),
    .id_srca_pc_i(id_srca_pc_i), .id_srcb_imm_i(id_srcb_imm_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .exmem_rd_i(exmem_rd_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_result_i(exmem_result_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i),
    .memwb_result_i(memwb_result_i), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_op_o(alu_op_o), .ex_valid_o(ex_valid_o), .ex_rd_o(ex_rd_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
    .ex_memwrite_o(ex_memwrite_o), .ex_store_data_o(ex_store_data_o),
    .ex_pc_o(ex_pc_o), .ex_illegal_o(ex_illegal_o), .hazard_o(hazard_o)
  );

  always #5 clk = ~clk;

  // Reference view of the instruction sitting in EX.
  typedef struct {
    logic        valid, rw, mr, mw, srca, srcb;
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
  } ex_t;
  ex_t m;

  function automatic void m_clear();
    m = '{valid: 0, rw: 0, mr: 0, mw: 0, srca: 0, srcb: 0, pc: 0, v1: 0, v2: 0,
          imm: 0, rs1: 0, rs2: 0, rd: 0, op: 0};
  endfunction

  function automatic logic m_legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
  endfunction

  function automatic logic [31:0] m_src(input logic [4:0] idx, input logic [31:0] lat);
`ifdef EX_FORWARD_EN
    if (idx == 0) return 32'd0;
    if (exmem_regwrite_i && exmem_rd_i == idx) return exmem_result_i;
    if (memwb_regwrite_i && memwb_rd_i == idx) return memwb_result_i;
`endif
    return lat;
  endfunction

  function automatic logic [31:0] m_b();
    logic [31:0] b;
    b = m.srcb ? m.imm : m_src(m.rs2, m.v2);
    if (m.op == 4'b0001 || m.op == 4'b0101 || m.op == 4'b1101) b = b % 32;
    return b;
  endfunction

  function automatic logic m_hazard();
    logic hit, h;
    hit = m.rd != 0 && (m.rd == id_rs1_i || m.rd == id_rs2_i);
    h = m.valid && m.mr && hit;
`ifndef EX_FORWARD_EN
    h = h || (m.valid && m.rw && m_legal(m.op) && hit);
    h = h || (exmem_regwrite_i && exmem_rd_i != 0 && (exmem_rd_i == id_rs1_i || exmem_rd_i == id_rs2_i));
    h = h || (memwb_regwrite_i && memwb_rd_i != 0 && (memwb_rd_i == id_rs1_i || memwb_rd_i == id_rs2_i));
`endif
    return id_valid_i && h;
  endfunction

  task automatic set_idle();
    stall_i = 0; flush_i = 0; id_valid_i = 0; id_pc_i = 0; id_rs1_val_i = 0;
    id_rs2_val_i = 0; id_imm_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
    id_aluop_i = 0; id_srca_pc_i = 0; id_srcb_imm_i = 0; id_regwrite_i = 0;
    id_memread_i = 0; id_memwrite_i = 0; exmem_rd_i = 0; exmem_regwrite_i = 0;
    exmem_result_i = 0; memwb_rd_i = 0; memwb_regwrite_i = 0; memwb_result_i = 0;
  endtask

  // One clock edge; the model follows the flush > stall > capture rules.
  task automatic tick();
    if (flush_i) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
    end else if (!stall_i) begin
      m.valid = id_valid_i;
      m.rw = id_valid_i && id_regwrite_i;
      m.mr = id_valid_i && id_memread_i;
      m.mw = id_valid_i && id_memwrite_i;
      m.srca = id_srca_pc_i; m.srcb = id_srcb_imm_i; m.pc = id_pc_i;
      m.v1 = id_rs1_val_i; m.v2 = id_rs2_val_i; m.imm = id_imm_i;
      m.rs1 = id_rs1_i; m.rs2 = id_rs2_i; m.rd = id_rd_i; m.op = id_aluop_i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ex_valid_o); end
    rst_n = 1;
    tick();
    checks++; if ({alu_a_o, alu_b_o, ex_pc_o, ex_store_data_o} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h want 0", alu_a_o, alu_b_o, ex_pc_o, ex_store_data_o); end
    checks++; if ({alu_op_o, ex_rd_o, ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_illegal_o, hazard_o} !== 15'd0) begin
      errors++; $display("FAIL reset_ctrl: got op=%b rd=%0d v=%b rw=%b mr=%b mw=%b il=%b hz=%b want 0",
                         alu_op_o, ex_rd_o, ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_illegal_o, hazard_o); end
  endtask

  task automatic test_basic_add();
    set_idle();
    id_valid_i = 1; id_aluop_i = 4'b0000; id_rs1_i = 1; id_rs1_val_i = 5;
    id_imm_i = 7; id_srcb_imm_i = 1; id_rd_i = 2; id_regwrite_i = 1; id_pc_i = 32'h40;
    tick();
    set_idle();
    #1;
    checks++; if (alu_a_o !== 32'd5) begin errors++; $display("FAIL add_a: got %h want 5", alu_a_o); end
    checks++; if (alu_b_o !== 32'd7) begin errors++; $display("FAIL add_b: got %h want 7", alu_b_o); end
    checks++; if ({ex_valid_o, ex_regwrite_o, ex_rd_o} !== {1'b1, 1'b1, 5'd2}) begin
      errors++; $display("FAIL add_ctrl: got v=%b rw=%b rd=%0d want 1 1 2", ex_valid_o, ex_regwrite_o, ex_rd_o); end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_a;
    set_idle();
    id_valid_i = 1; id_rs1_i = 3; id_rs1_val_i = 32'h99; id_rs2_i = 4; id_rs2_val_i = 32'h77;
    id_regwrite_i = 1; id_rd_i = 0;
    tick();
    set_idle();
    exmem_rd_i = 3; exmem_regwrite_i = 1; exmem_result_i = 32'h10;
    memwb_rd_i = 3; memwb_regwrite_i = 1; memwb_result_i = 32'h20;
    #1;
`ifdef EX_FORWARD_EN
    exp_a = 32'h10;
`else
    exp_a = 32'h99;
`endif
    checks++; if (alu_a_o !== exp_a) begin errors++; $display("FAIL fwd_exmem: got %h want %h", alu_a_o, exp_a); end
    exmem_regwrite_i = 0;
    #1;
`ifdef EX_FORWARD_EN
    exp_a = 32'h20;
`endif
    checks++; if (alu_a_o !== exp_a) begin errors++; $display("FAIL fwd_memwb: got %h want %h", alu_a_o, exp_a); end
    memwb_rd_i = 4; memwb_result_i = 32'h30;
    #1;
    checks++; if (ex_store_data_o !== m_src(4, 32'h77)) begin
      errors++; $display("FAIL fwd_store: got %h want %h", ex_store_data_o, m_src(4, 32'h77)); end
    // Decode reading the EX/MEM destination: only a hazard without forwarding.
    exmem_regwrite_i = 1; memwb_regwrite_i = 0; id_valid_i = 1; id_rs1_i = 3;
    #1;
`ifdef EX_FORWARD_EN
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL fwd_nohaz: got %b want 0", hazard_o); end
`else
    checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL raw_haz: got %b want 1", hazard_o); end
`endif
    set_idle();
    id_valid_i = 1; id_rs1_i = 0; id_rs1_val_i = 0;
    tick();
    set_idle();
    exmem_rd_i = 0; exmem_regwrite_i = 1; exmem_result_i = 32'h55;
    #1;
    checks++; if (alu_a_o !== 32'd0) begin errors++; $display("FAIL fwd_x0: got %h want 0", alu_a_o); end
  endtask

  task automatic test_stall_flush();
    set_idle();
    id_valid_i = 1; id_pc_i = 32'h100; id_aluop_i = 4'b0010; id_rs1_i = 1;
    id_rs1_val_i = 32'h11; id_imm_i = 32'h22; id_srcb_imm_i = 1; id_regwrite_i = 1; id_rd_i = 7;
    tick();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc_i = $urandom; id_rs1_val_i = $urandom; id_imm_i = $urandom;
      id_aluop_i = 4'($urandom); id_rd_i = 5'($urandom); id_valid_i = 1'($urandom);
      tick();
      checks++; if ({alu_a_o, alu_b_o, ex_pc_o, alu_op_o, ex_rd_o, ex_valid_o} !== {32'h11, 32'h22, 32'h100, 4'b0010, 5'd7, 1'b1}) begin
        errors++; $display("FAIL stall_hold: got a=%h b=%h pc=%h op=%b rd=%0d v=%b", alu_a_o, alu_b_o, ex_pc_o, alu_op_o, ex_rd_o, ex_valid_o); end
    end
    flush_i = 1; id_valid_i = 1; id_regwrite_i = 1;
    tick();
    checks++; if ({ex_valid_o, ex_regwrite_o} !== 2'b00) begin
      errors++; $display("FAIL stall_flush: got v=%b rw=%b want 0 0", ex_valid_o, ex_regwrite_o); end
    set_idle();
  endtask

  task automatic test_load_use();
    set_idle();
    id_valid_i = 1; id_memread_i = 1; id_regwrite_i = 1; id_rd_i = 5; id_rs1_i = 2; id_rs1_val_i = 32'h8;
    tick();
    set_idle();
    id_valid_i = 1; id_rs1_i = 1; id_rs2_i = 5;
    #1;
    checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL loaduse_hit: got %b want 1", hazard_o); end
    id_valid_i = 0;
    #1;
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL loaduse_idinv: got %b want 0", hazard_o); end
    id_valid_i = 1; id_memread_i = 1; id_regwrite_i = 1; id_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    tick();
    set_idle();
    id_valid_i = 1; id_rs1_i = 0; id_rs2_i = 0;
    #1;
    checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL loaduse_x0: got %b want 0", hazard_o); end
  endtask

  task automatic test_shift_illegal();
    set_idle();
    id_valid_i = 1; id_aluop_i = 4'b1101; id_rs2_i = 6; id_rs2_val_i = 32'hFFFF_FFE4;
    id_regwrite_i = 1; id_rd_i = 9;
    tick();
    set_idle();
    #1;
    checks++; if (alu_b_o !== 32'h0000_0004) begin errors++; $display("FAIL shift_mask: got %h want 00000004", alu_b_o); end
    checks++; if (ex_store_data_o !== 32'hFFFF_FFE4) begin errors++; $display("FAIL shift_store: got %h want ffffffe4", ex_store_data_o); end
    checks++; if ({ex_illegal_o, ex_regwrite_o} !== 2'b01) begin
      errors++; $display("FAIL shift_legal: got il=%b rw=%b want 0 1", ex_illegal_o, ex_regwrite_o); end
    id_valid_i = 1; id_aluop_i = 4'b1111; id_regwrite_i = 1; id_memwrite_i = 1; id_rd_i = 9;
    tick();
    set_idle();
    #1;
    checks++; if ({ex_illegal_o, ex_regwrite_o, ex_memwrite_o, alu_op_o} !== {3'b100, 4'b1111}) begin
      errors++; $display("FAIL illegal: got il=%b rw=%b mw=%b op=%b want 1 0 0 1111", ex_illegal_o, ex_regwrite_o, ex_memwrite_o, alu_op_o); end
  endtask

  task automatic test_async_reset();
    set_idle();
    id_valid_i = 1; id_regwrite_i = 1; id_aluop_i = 4'b0110; id_rd_i = 3; id_pc_i = 32'hABC;
    tick();
    set_idle();
    #2;
    rst_n = 0;
    #1;
    checks++; if ({ex_valid_o, ex_regwrite_o, alu_op_o, ex_pc_o} !== 38'd0) begin
      errors++; $display("FAIL async_reset: got v=%b rw=%b op=%b pc=%h want 0", ex_valid_o, ex_regwrite_o, alu_op_o, ex_pc_o); end
    @(posedge clk);
    #1;
    rst_n = 1;
    m_clear();
  endtask

  task automatic test_random();
    logic [31:0] ea;
    for (int i = 0; i < 400; i++) begin
      id_valid_i = ($urandom_range(0, 3) != 0);
      id_pc_i = $urandom; id_imm_i = $urandom;
      id_rs1_i = 5'($urandom_range(0, 3)); id_rs2_i = 5'($urandom_range(0, 3));
      id_rd_i = 5'($urandom_range(0, 3));
      id_rs1_val_i = (id_rs1_i == 0) ? 32'd0 : $urandom;
      id_rs2_val_i = (id_rs2_i == 0) ? 32'd0 : $urandom;
      id_aluop_i = 4'($urandom); id_srca_pc_i = 1'($urandom); id_srcb_imm_i = 1'($urandom);
      id_regwrite_i = 1'($urandom); id_memread_i = 1'($urandom); id_memwrite_i = 1'($urandom);
      exmem_rd_i = 5'($urandom_range(0, 3)); exmem_regwrite_i = 1'($urandom); exmem_result_i = $urandom;
      memwb_rd_i = 5'($urandom_range(0, 3)); memwb_regwrite_i = 1'($urandom); memwb_result_i = $urandom;
      stall_i = ($urandom_range(0, 6) == 0); flush_i = ($urandom_range(0, 9) == 0);
      #1;
      checks++; if ({ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_illegal_o} !==
                    {m.valid, m.rw && m_legal(m.op), m.mr, m.mw && m_legal(m.op), m.valid && !m_legal(m.op)}) begin
        errors++; $display("FAIL rnd_ctrl[%0d]: got v/rw/mr/mw/il=%b%b%b%b%b model valid=%b rw=%b mr=%b mw=%b op=%b",
                           i, ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_illegal_o, m.valid, m.rw, m.mr, m.mw, m.op); end
      checks++; if (hazard_o !== m_hazard()) begin
        errors++; $display("FAIL rnd_hazard[%0d]: got %b want %b", i, hazard_o, m_hazard()); end
      if (m.valid) begin
        ea = m.srca ? m.pc : m_src(m.rs1, m.v1);
        checks++; if (alu_a_o !== ea) begin errors++; $display("FAIL rnd_a[%0d]: got %h want %h", i, alu_a_o, ea); end
        checks++; if (alu_b_o !== m_b()) begin errors++; $display("FAIL rnd_b[%0d]: got %h want %h", i, alu_b_o, m_b()); end
        checks++; if (ex_store_data_o !== m_src(m.rs2, m.v2)) begin
          errors++; $display("FAIL rnd_store[%0d]: got %h want %h", i, ex_store_data_o, m_src(m.rs2, m.v2)); end
        checks++; if ({alu_op_o, ex_rd_o, ex_pc_o} !== {m.op, m.rd, m.pc}) begin
          errors++; $display("FAIL rnd_fields[%0d]: got op=%b rd=%0d pc=%h want %b %0d %h", i, alu_op_o, ex_rd_o, ex_pc_o, m.op, m.rd, m.pc); end
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_forwarding();
    test_stall_flush();
    test_load_use();
    test_shift_illegal();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus execute-side operand selection, directly upstream of the ALU.
- Captures decoded instruction fields each cycle and applies stall/flush.
- Resolves data hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU A, B and ALUop inputs and detects load-use hazards for the decode stage.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- stall_i  in  1  hold the stage contents
- flush_i  in  1  insert a bubble
- id_valid_i  in  1  decode slot holds an instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_val_i  in  XLEN  register-file rs1 value
- id_rs2_val_i  in  XLEN  register-file rs2 value
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_i  in  RA_W  rs1 index
- id_rs2_i  in  RA_W  rs2 index
- id_rd_i  in  RA_W  destination index
- id_aluop_i  in  4  ALU operation code
- id_srca_pc_i  in  1  A source: 1 = PC, 0 = rs1
- id_srcb_imm_i  in  1  B source: 1 = immediate, 0 = rs2
- id_regwrite_i  in  1  register write enable
- id_memread_i  in  1  load
- id_memwrite_i  in  1  store
- exmem_rd_i  in  RA_W  EX/MEM destination
- exmem_regwrite_i  in  1  EX/MEM write enable
- exmem_result_i  in  XLEN  EX/MEM ALU result
- memwb_rd_i  in  RA_W  MEM/WB destination
- memwb_regwrite_i  in  1  MEM/WB write enable
- memwb_result_i  in  XLEN  MEM/WB writeback value
- alu_a_o  out  XLEN  ALU operand A
- alu_b_o  out  XLEN  ALU operand B
- alu_op_o  out  4  ALU operation
- ex_valid_o  out  1  stage holds a valid instruction
- ex_rd_o  out  RA_W  destination
- ex_regwrite_o  out  1  qualified register write
- ex_memread_o  out  1  qualified load
- ex_memwrite_o  out  1  qualified store
- ex_store_data_o  out  XLEN  forwarded rs2 value for stores
- ex_pc_o  out  XLEN  instruction PC
- ex_illegal_o  out  1  valid instruction with undefined ALUop
- hazard_o  out  1  combinational stall request to decode

Behaviour:
- Reset: all stage registers are 0, so every output is 0 and alu_op_o = 4'b0000.
- Register update on each rising clk edge, in priority order:
  - flush_i = 1: valid and regwrite/memread/memwrite registers clear; other fields are don't-care. Flush overrides stall.
  - stall_i = 1: all registers hold.
  - Otherwise: capture all id_* fields.
  - If id_valid_i = 0 at capture, the control bits are stored as 0.
- Latency: one cycle from ID capture to operand outputs. All outputs are registered except forwarded operands and hazard_o, which are combinational on registered state plus exmem_*/memwb_*.
- Forwarding per source (rs1, rs2):
  - Use exmem_result_i if exmem_regwrite_i=1 and exmem_rd_i = source index.
  - Else use memwb_result_i if memwb_regwrite_i=1 and memwb_rd_i = source index.
  - Else use the latched register value.
  - Index 0 is never forwarded; a source of x0 always yields 0. EX/MEM has priority over MEM/WB.
- Operand selection:
  - alu_a_o = PC when srca_pc=1, else forwarded rs1.
  - alu_b_o = immediate when srcb_imm=1, else forwarded rs2.
  - ex_store_data_o is always forwarded rs2.
- Shift masking: for alu_op 0001, 0101, 1101, bits alu_b_o[XLEN-1:5] are forced to 0.
- Legal ALUop set: {0000, 1000, 0001, 0010, 0011, 0100, 0101, 1101, 0110, 0111}.
  - Any other code with ex_valid_o=1 sets ex_illegal_o=1 and forces ex_regwrite_o/ex_memwrite_o to 0.
  - alu_op_o passes through unchanged.
- hazard_o (load-use) = ex_valid_o & ex_memread_o & ex_rd_o≠0 & (ex_rd_o = id_rs1_i | ex_rd_o = id_rs2_i).
  - Only raised for id_valid_i=1.
  - Raising hazard_o does not stall this stage; the pipeline controller asserts flush_i on the next edge to insert the bubble.
- Reset asserted mid-operation clears state immediately, independent of clk.

Optional Feature:
- Macro EX_FORWARD_EN.
- Defined: forwarding as described above.
- Undefined: no forwarding; operands come straight from the latched register values. hazard_o additionally asserts on any valid RAW match (nonzero index, write enable set) against the EX stage, EX/MEM, or MEM/WB destinations.

Test Plan:
- Reset release → all outputs 0. Capture add (aluop 0000, rs1_val 5, imm 7, srcb_imm 1) → next cycle alu_a_o=5, alu_b_o=7, ex_valid_o=1.
- rs1=x3, exmem_rd=3 (result 0x10), memwb_rd=3 (result 0x20) → alu_a_o=0x10. Drop exmem_regwrite → 0x20. rs1=x0 with exmem_rd=0 → alu_a_o=0.
- Hold stall_i for 3 cycles while id_* changes → outputs frozen. Assert stall_i and flush_i together → ex_valid_o=0 and ex_regwrite_o=0 next cycle.
- EX holds a load to rd=x5; ID rs2=x5 with valid=1 → hazard_o=1. Same with rd=x0 → hazard_o=0.
- aluop 1101 with rs2_val 0xFFFF_FFE4 → alu_b_o=0x0000_0004. aluop 1111 → ex_illegal_o=1, ex_regwrite_o=0.
- EX_FORWARD_EN undefined: exmem_rd matches rs1 → alu_a_o is the latched value and hazard_o=1.
